// File: rtl/seg_display_scan.sv
// seg_display_scan
//   Display stage of the stopwatch. Time-multiplexes four BCD digits onto a
//   4-digit common-anode 7-segment display and flashes the digit picked by
//   sel while adjust mode is active. Scan and blink dividers run from clk.
//
// Parameters
//   SCAN_DIV   clk cycles per digit slot
//   BLINK_DIV  clk cycles per blink half-period
//
// Optional feature (compile-time macro)
//   LEADING_ZERO_BLANK_EN  blank the tens-of-minutes digit when it is zero,
//                          except while it is the adjusted digit in its
//                          visible blink phase.
//
// Ports
//   clk    in   board clock, single domain
//   rst    in   synchronous active-high reset
//   min_1  in   tens-of-minutes BCD value
//   min_0  in   minutes BCD value
//   sec_1  in   tens-of-seconds BCD value
//   sec_0  in   seconds BCD value
//   adj    in   adjust mode active
//   sel    in   adjusted digit: 00 sec_0, 01 sec_1, 10 min_0, 11 min_1
//   an     out  digit anodes, active low; an[0]=sec_0 .. an[3]=min_1
//   seg    out  segment cathodes, active low, {g,f,e,d,c,b,a}
//   dp     out  decimal point, active low (lit on slot 2 as the colon)

module seg_display_scan #(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLINK_DIV = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] min_1,
  input  logic [3:0] min_0,
  input  logic [3:0] sec_1,
  input  logic [3:0] sec_0,
  input  logic       adj,
  input  logic [1:0] sel,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int unsigned ScanW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BlinkW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [ScanW-1:0]  ScanLast  = ScanW'(SCAN_DIV - 1);
  localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_DIV - 1);

  localparam logic [6:0] SegBlank = 7'h7F;
  localparam logic [6:0] SegDash  = 7'b0111111;

  logic [ScanW-1:0]  scan_cnt_q, scan_cnt_d;
  logic [1:0]        slot_q, slot_d;
  logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
  logic              blink_on_q, blink_on_d;
  logic [3:0]        an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;

  logic [3:0] digit;
  logic [6:0] glyph;
  logic       blank;

  // BCD to active-low glyph; non-BCD codes show a dash.
  function automatic logic [6:0] decode(input logic [3:0] val);
    logic [6:0] g;
    case (val)
      4'd0:    g = 7'b1000000;
      4'd1:    g = 7'b1111001;
      4'd2:    g = 7'b0100100;
      4'd3:    g = 7'b0110000;
      4'd4:    g = 7'b0011001;
      4'd5:    g = 7'b0010010;
      4'd6:    g = 7'b0000010;
      4'd7:    g = 7'b1111000;
      4'd8:    g = 7'b0000000;
      4'd9:    g = 7'b0010000;
      default: g = SegDash;
    endcase
    return g;
  endfunction

  // Scan divider and slot pointer.
  always_comb begin
    scan_cnt_d = scan_cnt_q + ScanW'(1);
    slot_d     = slot_q;
    if (scan_cnt_q == ScanLast) begin
      scan_cnt_d = '0;
      slot_d     = slot_q + 2'd1;
    end
  end

  // Blink divider only runs in adjust mode so the selected digit is always
  // visible for a full half-period right after adj rises.
  always_comb begin
    blink_cnt_d = '0;
    blink_on_d  = 1'b1;
    if (adj) begin
      blink_on_d = blink_on_q;
      if (blink_cnt_q == BlinkLast) begin
        blink_cnt_d = '0;
        blink_on_d  = ~blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BlinkW'(1);
      end
    end
  end

  // Digit mux and decode for the current slot.
  always_comb begin
    unique case (slot_q)
      2'd0:    digit = sec_0;
      2'd1:    digit = sec_1;
      2'd2:    digit = min_0;
      default: digit = min_1;
    endcase
    glyph = decode(digit);
  end

  always_comb begin
    blank = adj && !blink_on_q && (slot_q == sel);
`ifdef LEADING_ZERO_BLANK_EN
    // Keep a zero tens-of-minutes digit visible while it is being adjusted.
    if ((slot_q == 2'd3) && (min_1 == 4'd0) && !(adj && (sel == 2'd3) && blink_on_q)) begin
      blank = 1'b1;
    end
`endif
  end

  always_comb begin
    an_d  = blank ? 4'hF : ~(4'b0001 << slot_q);
    seg_d = blank ? SegBlank : glyph;
    dp_d  = (slot_q != 2'd2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt_q  <= '0;
      slot_q      <= 2'd0;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
      an_q        <= 4'hF;
      seg_q       <= SegBlank;
      dp_q        <= 1'b1;
    end else begin
      scan_cnt_q  <= scan_cnt_d;
      slot_q      <= slot_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_seg_display_scan.sv
// tb_seg_display_scan
//   Directed, table-driven bench for seg_display_scan with SCAN_DIV=4 and
//   BLINK_DIV=16. Expected values are hand-computed glyphs and anode patterns.

module tb_seg_display_scan;

  logic       clk;
  logic       rst;
  logic [3:0] min_1, min_0, sec_1, sec_0;
  logic       adj;
  logic [1:0] sel;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int total;
  int bad;
  int cyc;  // clock edges since reset release

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } out_vec_t;

  typedef struct {
    logic [3:0] digit;
    logic [6:0] seg;
  } dec_vec_t;

  out_vec_t nominal[4];
  dec_vec_t dec_tab[16];

  seg_display_scan #(
    .SCAN_DIV (4),
    .BLINK_DIV(16)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .min_1(min_1),
    .min_0(min_0),
    .sec_1(sec_1),
    .sec_0(sec_0),
    .adj  (adj),
    .sel  (sel),
    .an   (an),
    .seg  (seg),
    .dp   (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    if (!rst) cyc++;
  endtask

  // Run until the next edge shows the first cycle of slot s (at most 15 edges).
  task automatic wait_slot_start(input int s);
    while ((cyc % 16) != s * 4) step();
  endtask

  task automatic chk(input string name, input logic [3:0] an_e, input logic [6:0] seg_e,
                     input logic dp_e);
    total++;
    if (an !== an_e || seg !== seg_e || dp !== dp_e) begin
      bad++;
      $display("FAIL %s cyc=%0d: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
               name, cyc, an, seg, dp, an_e, seg_e, dp_e);
    end
  endtask

  initial begin
    int s;
    bit vis;
    total = 0;
    bad   = 0;
    cyc   = 0;

    nominal[0] = '{an: 4'b1110, seg: 7'b0011001, dp: 1'b1};
    nominal[1] = '{an: 4'b1101, seg: 7'b0110000, dp: 1'b1};
    nominal[2] = '{an: 4'b1011, seg: 7'b0100100, dp: 1'b0};
    nominal[3] = '{an: 4'b0111, seg: 7'b1111001, dp: 1'b1};

    dec_tab[0]  = '{digit: 4'd0,  seg: 7'b1000000};
    dec_tab[1]  = '{digit: 4'd1,  seg: 7'b1111001};
    dec_tab[2]  = '{digit: 4'd2,  seg: 7'b0100100};
    dec_tab[3]  = '{digit: 4'd3,  seg: 7'b0110000};
    dec_tab[4]  = '{digit: 4'd4,  seg: 7'b0011001};
    dec_tab[5]  = '{digit: 4'd5,  seg: 7'b0010010};
    dec_tab[6]  = '{digit: 4'd6,  seg: 7'b0000010};
    dec_tab[7]  = '{digit: 4'd7,  seg: 7'b1111000};
    dec_tab[8]  = '{digit: 4'd8,  seg: 7'b0000000};
    dec_tab[9]  = '{digit: 4'd9,  seg: 7'b0010000};
    dec_tab[10] = '{digit: 4'hA,  seg: 7'b0111111};
    dec_tab[11] = '{digit: 4'hB,  seg: 7'b0111111};
    dec_tab[12] = '{digit: 4'hC,  seg: 7'b0111111};
    dec_tab[13] = '{digit: 4'hD,  seg: 7'b0111111};
    dec_tab[14] = '{digit: 4'hE,  seg: 7'b0111111};
    dec_tab[15] = '{digit: 4'hF,  seg: 7'b0111111};

    rst   = 1'b1;
    min_1 = 4'd1;
    min_0 = 4'd2;
    sec_1 = 4'd3;
    sec_0 = 4'd4;
    adj   = 1'b0;
    sel   = 2'd0;

    // Reset state.
    step();
    step();
    chk("reset", 4'b1111, 7'h7F, 1'b1);

    // Normal scan, two full refresh periods.
    rst = 1'b0;
    cyc = 0;
    for (int i = 0; i < 32; i++) begin
      step();
      s = ((cyc - 1) / 4) % 4;
      chk("scan", nominal[s].an, nominal[s].seg, nominal[s].dp);
    end

    // Decode every code on slot 0; input change shows one edge later.
    for (int i = 0; i < 16; i++) begin
      wait_slot_start(0);
      sec_0 = dec_tab[i].digit;
      step();
      chk("decode", 4'b1110, dec_tab[i].seg, 1'b1);
    end
    sec_0 = 4'd4;

    // Blink on sec_1: visible 16 edges, blanked 16, repeat; others untouched.
    wait_slot_start(0);
    adj = 1'b1;
    sel = 2'd1;
    for (int j = 1; j <= 64; j++) begin
      step();
      s   = ((cyc - 1) / 4) % 4;
      vis = (((j - 1) / 16) % 2) == 0;
      if (s == 1 && !vis) chk("blink_blank", 4'b1111, 7'h7F, 1'b1);
      else chk("blink_vis", nominal[s].an, nominal[s].seg, nominal[s].dp);
    end
    // Edges 65..80 visible, 81..96 blanked; leaving adj unblanks at once.
    for (int j = 0; j < 20; j++) step();
    step();
    chk("blink_blank_pre_exit", 4'b1111, 7'h7F, 1'b1);
    adj = 1'b0;
    step();
    chk("adj_exit_visible", 4'b1101, 7'b0110000, 1'b1);
    sel = 2'd0;

    // Reset mid-scan during slot 2.
    wait_slot_start(2);
    step();
    chk("slot2_pre_rst", 4'b1011, 7'b0100100, 1'b0);
    rst = 1'b1;
    step();
    chk("mid_rst", 4'b1111, 7'h7F, 1'b1);
    rst = 1'b0;
    cyc = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("restart_slot0", 4'b1110, 7'b0011001, 1'b1);
    end
    step();
    chk("restart_slot1", 4'b1101, 7'b0110000, 1'b1);

    // Leading zero on min_1.
    min_1 = 4'd0;
    wait_slot_start(3);
    step();
`ifdef LEADING_ZERO_BLANK_EN
    chk("lz_blank", 4'b1111, 7'h7F, 1'b1);
`else
    chk("lz_shown", 4'b0111, 7'b1000000, 1'b1);
`endif
    // Adjusting min_1: zero shown in the visible phase, blanked in the other.
    wait_slot_start(0);
    adj = 1'b1;
    sel = 2'd3;
    for (int j = 0; j < 13; j++) step();
    chk("lz_adj_visible", 4'b0111, 7'b1000000, 1'b1);
    for (int j = 0; j < 16; j++) step();
    chk("lz_adj_blank", 4'b1111, 7'h7F, 1'b1);
    adj = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
